// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg
// Shared definitions for the program sequencer:
//   - state encodings (3-bit, also driven out on the `state` port)
//   - error-code constants reported on `err_code`
//   - default instruction-memory depth and its address width
package prog_seq_pkg;

    // Instruction memory geometry. The address port is fixed at 5 bits.
    localparam int DEPTH_DEFAULT = 32;
    localparam int ADDR_W        = 5;

    // Sequencer state encodings.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_CSUM   = 3'd2;
    localparam state_t ST_LOADED = 3'd3;
    localparam state_t ST_RUN    = 3'd4;
    localparam state_t ST_DONE   = 3'd5;
    localparam state_t ST_ERROR  = 3'd6;

    // Error codes.
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_CSUM     = 2'd3;

endpackage

// File: rtl/prog_seq_wdt.sv
// prog_seq_wdt
// Run-cycle counter / watchdog for the program sequencer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        forces the counter to zero (has priority over enable)
//   enable       counts up by one per cycle
//   count        registered counter value (cycles already completed)
//   limit_hit    high in the enabled cycle whose increment reaches WDT_LIMIT
module prog_seq_wdt #(
    parameter int WDT_W     = 12,
    parameter int WDT_LIMIT = 4000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WDT_W-1:0] count,
    output logic             limit_hit
);

    logic [WDT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + WDT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

    // Flag the cycle in which the counter would step onto the limit, so the
    // owner can leave the counting state after exactly WDT_LIMIT cycles.
    assign limit_hit = enable && (cnt_q == WDT_W'(WDT_LIMIT - 1));

endmodule

// File: rtl/prog_seq_ctrl.sv
// prog_seq_ctrl
// Program sequencer for the accumulator core: streams a program from the
// host into the 32x8 instruction memory, releases the core from reset,
// watches for HALT and bounds execution with a watchdog.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   hs_valid/hs_data/hs_last/hs_ready   host byte stream (valid/ready)
//   cmd_load/cmd_start/cmd_abort        one-cycle command pulses
//   mem_we/mem_addr/mem_wdata           instruction-memory write port
//   cpu_rst_n       registered core reset, active-low
//   cpu_halted      core HALT indication
//   state           current state encoding
//   err_code        0 none, 1 overflow, 2 timeout, 3 checksum
//   prog_len        bytes in the last complete load (1..32)
//   run_cycles      RUN cycles of the last halted run, halt cycle included
//
// Build option: PROG_SEQ_CHECKSUM_EN adds a CSUM state that accepts one
// extra byte after the last program byte and compares it against the XOR
// of all loaded bytes.
module prog_seq_ctrl
    import prog_seq_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int WDT_W     = 12,
    parameter int WDT_LIMIT = 4000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs_valid,
    input  logic [7:0]        hs_data,
    input  logic              hs_last,
    output logic              hs_ready,
    input  logic              cmd_load,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst_n,
    input  logic              cpu_halted,
    output logic [2:0]        state,
    output logic [1:0]        err_code,
    output logic [5:0]        prog_len,
    output logic [WDT_W-1:0]  run_cycles
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]        err_q, err_d;
    logic [5:0]        len_q, len_d;
    logic [WDT_W-1:0]  runc_q, runc_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    // One-cycle marker: a re-run from DONE holds the core in reset for a
    // cycle (state stays DONE) before entering RUN, so a core still showing
    // HALT from the previous run is not mistaken for an immediate halt.
    logic              restart_q, restart_d;
`ifdef PROG_SEQ_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic             beat;
    logic             start_load;
    logic [WDT_W-1:0] wdt_count;
    logic             wdt_hit;

    prog_seq_wdt #(
        .WDT_W     (WDT_W),
        .WDT_LIMIT (WDT_LIMIT)
    ) u_wdt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state_q != ST_RUN),
        .enable    (state_q == ST_RUN),
        .count     (wdt_count),
        .limit_hit (wdt_hit)
    );

    // Ready depends on registered state only.
    always_comb begin
        hs_ready = (state_q == ST_LOAD);
`ifdef PROG_SEQ_CHECKSUM_EN
        if (state_q == ST_CSUM) hs_ready = 1'b1;
`endif
    end

    assign beat = hs_valid && hs_ready;

    // Zero-latency write port; address/data are parked at zero when idle.
    assign mem_we    = beat && (state_q == ST_LOAD);
    assign mem_addr  = mem_we ? wr_ptr_q : '0;
    assign mem_wdata = mem_we ? hs_data : 8'h00;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        err_d      = err_q;
        len_d      = len_q;
        runc_d     = runc_q;
        restart_d  = 1'b0;
        start_load = 1'b0;
`ifdef PROG_SEQ_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            ST_IDLE: start_load = cmd_load;

            ST_LOAD: begin
                if (beat) begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
`ifdef PROG_SEQ_CHECKSUM_EN
                    csum_d   = csum_q ^ hs_data;
`endif
                    if (hs_last) begin
                        len_d = {1'b0, wr_ptr_q} + 6'd1;
`ifdef PROG_SEQ_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_LOADED;
`endif
                    end else if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        // Last slot written without an end marker.
                        state_d = ST_ERROR;
                        err_d   = ERR_OVERFLOW;
                    end
                end
            end

`ifdef PROG_SEQ_CHECKSUM_EN
            ST_CSUM: begin
                if (beat) begin
                    if (hs_data == csum_q) begin
                        state_d = ST_LOADED;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CSUM;
                    end
                end
            end
`endif

            ST_LOADED: begin
                if (cmd_load)       start_load = 1'b1;
                else if (cmd_start) state_d    = ST_RUN;
            end

            ST_RUN: begin
                // Halt beats the watchdog when both land on the same cycle.
                if (cpu_halted) begin
                    state_d = ST_DONE;
                    runc_d  = wdt_count + WDT_W'(1);
                end else if (wdt_hit) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end

            ST_DONE: begin
                if (cmd_load)       start_load = 1'b1;
                else if (restart_q) state_d    = ST_RUN;
                else if (cmd_start) restart_d  = 1'b1;
            end

            ST_ERROR: start_load = cmd_load;

            default: state_d = ST_IDLE;
        endcase

        if (start_load) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            err_d    = ERR_NONE;
`ifdef PROG_SEQ_CHECKSUM_EN
            csum_d   = 8'h00;
`endif
        end

        if (cmd_abort) begin
            state_d   = ST_IDLE;
            err_d     = ERR_NONE;
            restart_d = 1'b0;
        end

        // Core runs only in RUN and DONE, minus the re-run reset cycle.
        cpu_rst_n_d = (state_d == ST_RUN) || ((state_d == ST_DONE) && !restart_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            err_q       <= ERR_NONE;
            len_q       <= '0;
            runc_q      <= '0;
            cpu_rst_n_q <= 1'b0;
            restart_q   <= 1'b0;
`ifdef PROG_SEQ_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            err_q       <= err_d;
            len_q       <= len_d;
            runc_q      <= runc_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            restart_q   <= restart_d;
`ifdef PROG_SEQ_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign state      = state_q;
    assign err_code   = err_q;
    assign prog_len   = len_q;
    assign run_cycles = runc_q;
    assign cpu_rst_n  = cpu_rst_n_q;

endmodule
